// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle.
// The master modport is the pipeline side and the slave modport is the hazard unit.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  ICacheMiss;
  logic                  DCacheMiss;
  logic                  BranchE;
  logic                  JalrE;
  logic                  JalD;
  logic                  MdStartE;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic [1:0]            RegReadD;
  logic [1:0]            RegReadE;
  logic [2:0]            RegWriteM;
  logic [2:0]            RegWriteW;
  logic                  MemToRegE;
  logic                  StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic                  StallM, FlushM, StallW, FlushW;
  logic [1:0]            Forward1E;
  logic [1:0]            Forward2E;
  logic                  MdBusy;
  logic                  MdDone;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegReadD, RegReadE, RegWriteM, RegWriteW, MemToRegE,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW, Forward1E, Forward2E, MdBusy, MdDone
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MdStartE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegReadD, RegReadE, RegWriteM, RegWriteW, MemToRegE,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW, Forward1E, Forward2E, MdBusy, MdDone
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit: forwarding, load-use bubbles, cache-miss stalls and a mul/div interlock.
// Defining HAZARD_PERF_CNT_EN adds the StallCycCnt/FlushCycCnt performance counters.
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             CpuRstN,
  hazard_unit_mc_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCycCnt,
  output logic [CNT_W-1:0] FlushCycCnt
`endif
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam bit         MD_MULTI = (MD_LAT > 1);
  localparam logic [7:0] MD_LOAD  = 8'((MD_LAT > 1) ? (MD_LAT - 2) : 0);

  state_t     state;
  logic [7:0] mdcnt;
  logic       loaduse;
  logic       mdstall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic [2:0]            wr_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic [2:0]            wr_w
  );
    if (used && rd_m == rs && rd_m != REG_ADDR_W'(0) && wr_m != 3'd0)
      return 2'b10;
    else if (used && rd_w == rs && rd_w != REG_ADDR_W'(0) && wr_w != 3'd0)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    loaduse = hz.MemToRegE && (hz.RdE != REG_ADDR_W'(0)) &&
              ((hz.RdE == hz.Rs1D && hz.RegReadD[1]) ||
               (hz.RdE == hz.Rs2D && hz.RegReadD[0]));
    mdstall = (state == RUN && hz.MdStartE && MD_MULTI) ||
              (state == MD_BUSY && mdcnt != 8'd0);
  end

  // Reset forces a global flush; otherwise the first matching hazard class wins.
  always_comb begin
    hz.StallF = 1'b0;
    hz.FlushF = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushD = 1'b0;
    hz.StallE = 1'b0;
    hz.FlushE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushM = 1'b0;
    hz.StallW = 1'b0;
    hz.FlushW = 1'b0;
    if (!CpuRstN) begin
      hz.FlushF = 1'b1;
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.DCacheMiss) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (mdstall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.FlushM = 1'b1;
    end else if (loaduse) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (hz.BranchE || hz.JalrE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (hz.JalD) begin
      hz.FlushD = 1'b1;
    end else if (hz.ICacheMiss) begin
      hz.StallF = 1'b1;
      hz.FlushD = 1'b1;
    end
  end

  always_comb begin
    hz.Forward1E = 2'b00;
    hz.Forward2E = 2'b00;
    if (CpuRstN) begin
      hz.Forward1E = fwd_sel(hz.Rs1E, hz.RegReadE[1], hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      hz.Forward2E = fwd_sel(hz.Rs2E, hz.RegReadE[0], hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    end
    hz.MdBusy = CpuRstN && (state == MD_BUSY);
    hz.MdDone = CpuRstN && (state == MD_BUSY) && !hz.DCacheMiss && (mdcnt == 8'd0);
  end

  // MdStartE is ignored while busy: the finishing op is still in E on its done cycle.
  always_ff @(posedge clk) begin
    if (!CpuRstN) begin
      state <= RUN;
      mdcnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (hz.MdStartE && MD_MULTI && !hz.DCacheMiss) begin
            state <= MD_BUSY;
            mdcnt <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          if (!hz.DCacheMiss) begin
            if (mdcnt != 8'd0)
              mdcnt <= mdcnt - 8'd1;
            else
              state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_prio;

  // Counts only the flushes raised by load-use, control transfers and I-cache bubbles.
  assign flush_prio = CpuRstN && !hz.DCacheMiss && !mdstall &&
                      (loaduse || hz.BranchE || hz.JalrE || hz.JalD || hz.ICacheMiss);

  always_ff @(posedge clk) begin
    if (!CpuRstN) begin
      StallCycCnt <= '0;
      FlushCycCnt <= '0;
    end else begin
      if (hz.StallF)
        StallCycCnt <= StallCycCnt + CNT_W'(1);
      if (flush_prio)
        FlushCycCnt <= FlushCycCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised successor hazard unit for the 5-stage RISC-V pipeline. Resolves data hazards by forwarding and load-use bubbles, and control hazards by flushing. Adds real handling of ICacheMiss/DCacheMiss and a multi-cycle execute (mul/div) interlock, sequenced by an internal FSM and countdown counter. It drives the Stall/Flush pins of all five stage registers and the two E-stage forwarding muxes.

Parameters:
REG_ADDR_W, 5, register-number width for Rs/Rd ports.
MD_LAT, 4, total cycles a multi-cycle op occupies E (1..255); 1 disables the interlock.
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock
CpuRstN  in  1  synchronous active-low reset; also forces global flush while low
ICacheMiss  in  1  level; fetch not yet valid
DCacheMiss  in  1  level; M-stage memory access not complete
BranchE, JalrE, JalD  in  1 each  taken branch / jalr in E, jal in D
MdStartE  in  1  instruction in E is multi-cycle (mul/div)
Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_ADDR_W each  register numbers
RegReadD, RegReadE  in  2  bit1 = rs1 used, bit0 = rs2 used
RegWriteM, RegWriteW  in  3  non-zero = stage writes Rd
MemToRegE  in  1  E instruction is a load
StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each  stage-register controls
Forward1E, Forward2E  out  2  00 = regfile, 10 = from M, 01 = from W
MdBusy  out  1  multi-cycle op in progress (state MD_BUSY)
MdDone  out  1  one-cycle pulse: final cycle of multi-cycle op

Behaviour:
- State: FSM {RUN, MD_BUSY} plus an 8-bit down-counter mdcnt. All registers update on posedge clk only.
- Reset: CpuRstN==0 at an edge -> state=RUN, mdcnt=0. While CpuRstN==0 the outputs are combinational: all Flush*=1, all Stall*=0, Forward*=00, MdBusy=0, MdDone=0.
- Forwarding, per operand (shown for rs1; rs2 uses Rs2E/RegReadE[0]):
  - 10 if RdM==Rs1E, RegReadE[1], RdM!=0, RegWriteM!=0.
  - Else 01 if the same test passes with RdW/RegWriteW.
  - Else 00.
  - M has priority over W. Forwarding is independent of stalls.
- loaduse = MemToRegE && RdE!=0 && ((RdE==Rs1D && RegReadD[1]) || (RdE==Rs2D && RegReadD[0])).
- mdstall = (RUN && MdStartE && MD_LAT>1) || (MD_BUSY && mdcnt!=0).
- Stall/Flush priority, first match wins; signals not listed are 0:
  1. DCacheMiss -> StallF, StallD, StallE, StallM = 1; FlushW = 1.
  2. mdstall -> StallF, StallD, StallE = 1; FlushM = 1.
  3. loaduse -> StallF, StallD = 1; FlushE = 1.
  4. BranchE or JalrE -> FlushD, FlushE = 1. Overrides ICacheMiss: the fetch is wrong-path, so the PC must redirect.
  5. JalD -> FlushD = 1. Overrides ICacheMiss for the same reason.
  6. ICacheMiss -> StallF = 1; FlushD = 1 (bubble).
  7. Otherwise all 0.
- FSM transitions:
  - RUN -> MD_BUSY when MdStartE && MD_LAT>1 && !DCacheMiss; load mdcnt = MD_LAT-2.
  - MD_BUSY:
    - DCacheMiss -> hold state and mdcnt.
    - Else if mdcnt!=0 -> mdcnt decrements.
    - Else (mdcnt==0) -> MdDone=1, return to RUN.
  - MdStartE is ignored in MD_BUSY; the same instruction is still in E on its done cycle, so it must not retrigger.
- Latency: a multi-cycle op spends exactly MD_LAT cycles in E and produces MD_LAT-1 stall cycles, plus any DCacheMiss cycles.
- Reset during MD_BUSY aborts the op: state RUN next cycle, no MdDone.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds output ports StallCycCnt and FlushCycCnt (each CNT_W bits). Both are cleared by reset.
  - StallCycCnt +1 every cycle StallF==1.
  - FlushCycCnt +1 every cycle FlushD or FlushE is 1 from priorities 3–6.
  - Counters wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, RegReadE=10 -> Forward1E=10, Forward2E=00. Same with RdM=0 -> Forward1E=01.
2. Load-use: MemToRegE=1, RdE=7, Rs2D=7, RegReadD=01 -> StallF=StallD=FlushE=1, all other signals 0, for exactly one cycle.
3. MD_LAT=4, MdStartE held until done -> stall 3 cycles (FlushM=1 each), MdBusy high cycles 2–4, MdDone pulse in cycle 4, no retrigger. Repeat with DCacheMiss for 2 cycles mid-op -> done delayed 2 cycles, StallM=1 and FlushW=1 during the miss.
4. ICacheMiss=1 with BranchE=1 -> FlushD=FlushE=1, StallF=0. ICacheMiss with JalD -> FlushD=1, StallF=0. ICacheMiss alone -> StallF=1, FlushD=1.
5. CpuRstN=0 while in MD_BUSY with mdcnt=2 -> all Flush=1 during reset. After release: RUN, MdBusy=0, no MdDone.
6. With HAZARD_PERF_CNT_EN and CNT_W=4: 17 load-use cycles -> StallCycCnt=1 (wrap). FlushCycCnt matches the flush count.
